// File: rtl/inpmem_pkg.sv
// rtl/inpmem_pkg.sv - shared constants and types for the banked input memory streamer
package inpmem_pkg;

    localparam int MEM8_ADDR_W = 8;
    localparam int MEM8_DEPTH  = 256;
    localparam int FIFO_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/inpmem_bank.sv
// rtl/inpmem_bank.sv - one bank: LANES mem8 macros sharing an address, per-lane chip enable
module inpmem_bank
    import inpmem_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   clk,
    input  logic                   sel,
    input  logic [LANES-1:0]       lane_en,
    input  logic                   wen,
    input  logic [MEM8_ADDR_W-1:0] addr,
    input  logic [8*LANES-1:0]     d,
    output logic [8*LANES-1:0]     q
);

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic cen;
        assign cen = ~(sel & lane_en[k]);

        mem8 u_mem (
            .clk (clk),
            .cen (cen),
            .wen (wen),
            .a   (addr),
            .d   (d[8*k +: 8]),
            .q   (q[8*k +: 8])
        );
    end

endmodule

// File: rtl/mem8.sv
// rtl/mem8.sv - 256x8 single-port SRAM macro model, active-low CEN/WEN, registered read
module mem8
    import inpmem_pkg::*;
(
    input  logic                   clk,
    input  logic                   cen,
    input  logic                   wen,
    input  logic [MEM8_ADDR_W-1:0] a,
    input  logic [7:0]             d,
    output logic [7:0]             q
);

    logic [7:0] mem [MEM8_DEPTH];

    always_ff @(posedge clk) begin
        if (!cen) begin
            if (!wen) begin
                mem[a] <= d;
            end else begin
                q <= mem[a];
            end
        end
    end

endmodule

// File: rtl/inpmem_stream.sv
// rtl/inpmem_stream.sv - banked input memory with byte-enabled writes and a burst-read streamer
module inpmem_stream
    import inpmem_pkg::*;
#(
    parameter int NUM_BANKS   = 256,
    parameter int BANK_ADDR_W = 8,
    parameter int LANES       = 1,
    parameter int LEN_W       = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic [BANK_ADDR_W+7:0]         wr_addr,
    input  logic [8*LANES-1:0]             wr_data,
    input  logic [LANES-1:0]               wr_be,
    input  logic                           rd_start,
    input  logic [BANK_ADDR_W+7:0]         rd_base,
    input  logic [LEN_W-1:0]               rd_len,
    output logic                           busy,
    output logic                           done,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [8*LANES-1:0]             out_data,
    output logic                           out_last
);

    localparam int AW = BANK_ADDR_W + MEM8_ADDR_W;
    localparam int DW = 8 * LANES;

    state_t                 state, state_nx;
    logic [AW-1:0]          rd_addr;
    logic [LEN_W-1:0]       remaining;
    logic [BANK_ADDR_W-1:0] rd_bank_q;
    logic                   inflight, inflight_last;
    logic [DW-1:0]          fifo_data [FIFO_DEPTH];
    logic                   fifo_last [FIFO_DEPTH];
    logic                   wr_ptr, rd_ptr;
    logic [1:0]             fifo_count;
    logic                   done_q;
    logic                   wr_fire, start_idle, issue, pop, push;
    logic [2:0]             occ;
    logic [DW-1:0]          bank_q [NUM_BANKS];
    logic [MEM8_ADDR_W-1:0] mem_addr;
    logic [LANES-1:0]       lane_en;
    logic                   mem_wen;

    assign busy       = (state != IDLE);
    assign wr_ready   = ~busy;
    assign wr_fire    = wr_valid & wr_ready & rst_n;
    assign start_idle = (state == IDLE) & rd_start;
    assign out_valid  = (fifo_count != 2'd0);
    assign out_data   = fifo_data[rd_ptr];
    assign out_last   = out_valid & fifo_last[rd_ptr];
    assign done       = done_q;
    assign pop        = out_valid & out_ready;
    assign push       = inflight;

    // Credit: FIFO entries plus the word in flight, net of this cycle's pop, must leave a free slot.
    assign occ   = 3'(fifo_count) + {2'b00, inflight} - {2'b00, pop};
    assign issue = rst_n && (state == STREAM) && (remaining != '0) && (occ < 3'(FIFO_DEPTH));

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (rd_start && rd_len != '0) state_nx = STREAM;
            STREAM:  if (issue && remaining == LEN_W'(1)) state_nx = DRAIN;
            DRAIN:   if (!inflight && (fifo_count == 2'd0 || (fifo_count == 2'd1 && pop)))
                         state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            rd_addr       <= '0;
            remaining     <= '0;
            rd_bank_q     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            wr_ptr        <= 1'b0;
            rd_ptr        <= 1'b0;
            fifo_count    <= 2'd0;
            done_q        <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            state  <= state_nx;
            done_q <= (start_idle && rd_len == '0) || (pop && out_last);
            if (start_idle) begin
                rd_addr   <= rd_base;
                remaining <= rd_len;
            end else if (issue) begin
                rd_addr   <= rd_addr + AW'(1);
                remaining <= remaining - LEN_W'(1);
            end
            inflight <= issue;
            if (issue) begin
                rd_bank_q     <= rd_addr[AW-1:MEM8_ADDR_W];
                inflight_last <= (remaining == LEN_W'(1));
            end
            if (push) begin
                fifo_data[wr_ptr] <= bank_q[rd_bank_q];
                fifo_last[wr_ptr] <= inflight_last;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Writes happen only in IDLE and reads only in STREAM, so the shared bank bus never conflicts.
    assign mem_addr = wr_fire ? wr_addr[MEM8_ADDR_W-1:0] : rd_addr[MEM8_ADDR_W-1:0];
    assign lane_en  = wr_fire ? wr_be : '1;
    assign mem_wen  = ~wr_fire;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic sel;
        assign sel = (wr_fire && wr_addr[AW-1:MEM8_ADDR_W] == BANK_ADDR_W'(b)) ||
                     (issue && rd_addr[AW-1:MEM8_ADDR_W] == BANK_ADDR_W'(b));

        inpmem_bank #(.LANES(LANES)) u_bank (
            .clk     (clk),
            .sel     (sel),
            .lane_en (lane_en),
            .wen     (mem_wen),
            .addr    (mem_addr),
            .d       (wr_data),
            .q       (bank_q[b])
        );
    end

endmodule

// File: doc/inpmem_stream.md
Name: inpmem_stream

Overview:
Banked input memory for the systolic array, built from mem8 macros (256 words x 8 bits, active-low CEN/WEN, 1-cycle registered read).
- Generalises the input memory to multi-byte words (LANES byte lanes) with byte-enabled writes.
- Adds a burst-read streamer: one start command reads LEN consecutive words and delivers them on a valid/ready stream, with backpressure, to the array feeder.

Parameters:
NUM_BANKS, 256, number of mem8 banks along depth.
BANK_ADDR_W, 8, bank-select width; must equal log2(NUM_BANKS).
LANES, 1, bytes per word; each bank holds LANES mem8 instances sharing one address.
LEN_W, 16, width of the burst length field.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_valid  in  1  write request
wr_ready  out  1  write accepted when wr_valid & wr_ready; equals ~busy
wr_addr  in  BANK_ADDR_W+8  word address; [BANK_ADDR_W+7:8] selects the bank, [7:0] selects the row
wr_data  in  8*LANES  write word; lane k is bits [8k+7:8k]
wr_be  in  LANES  per-lane byte enable
rd_start  in  1  burst start, sampled only in IDLE
rd_base  in  BANK_ADDR_W+8  first word address of the burst
rd_len  in  LEN_W  number of words in the burst
busy  out  1  high in STREAM and DRAIN
done  out  1  one-cycle pulse at end of burst
out_valid  out  1  stream data valid
out_ready  in  1  consumer ready
out_data  out  8*LANES  stream word
out_last  out  1  high with the final word of a burst

Behaviour:
- Reset (rst_n=0 at an edge):
  - state=IDLE; wr_ready=1; busy=0; done=0; out_valid=0; out_last=0; out_data=0.
  - Output FIFO and in-flight flag are cleared; all mem8 CEN are held high.
  - SRAM contents are not cleared.
  - Reset mid-burst aborts the burst: no done pulse, and no further beats are emitted.
- FSM states: IDLE, STREAM, DRAIN.
- IDLE:
  - Write: wr_valid & wr_ready drives the selected bank's lanes, CEN low only where wr_be[k]=1, WEN low, for that cycle. The write is complete at the next edge. Unselected banks and lanes keep CEN high.
  - Start with rd_len!=0: rd_start loads rd_addr=rd_base and remaining issues=rd_len, then enters STREAM.
  - Start with rd_len==0: done pulses in the next cycle; the FSM stays in IDLE and emits nothing.
  - Write and start in the same cycle: the write is performed and the start is also accepted.
- STREAM:
  - A read issue drives CEN low and WEN high on all lanes of bank rd_addr[BANK_ADDR_W+7:8].
  - The read bank index is registered for the output mux, as for a 1-cycle SRAM.
  - Issue rule: issue iff issues remain and (fifo_count + inflight - pop) < 2, where pop = out_valid & out_ready. This guarantees the 2-entry output FIFO never overflows.
  - Each issue increments rd_addr modulo 2^(BANK_ADDR_W+8), so the burst wraps from the top address to 0.
  - Returned data is pushed into the FIFO at the edge after the read edge.
  - After the last issue, the FSM moves to DRAIN.
- DRAIN: stay until the FIFO is empty and nothing is in flight, then return to IDLE. done pulses for one cycle in the cycle after the handshake of the out_last beat.
- Latency: with rd_start accepted at edge E0, the first issue is captured at E1 and the data is pushed at E2. out_valid is high in the cycle after E2.
- Throughput: with out_ready held high, one word per cycle sustained and no bubbles after the first.
- Backpressure:
  - out_data, out_valid and out_last hold stable while out_valid & ~out_ready.
  - No beat is dropped or duplicated.
  - Issuing stalls when credit is exhausted.
- out_last is high exactly on beat number rd_len.
- Writes are blocked (wr_ready=0) while busy; mem8 is single-ported.
- rd_start is ignored while busy.

Decomposition:
- Package inpmem_pkg holds:
  - MEM8_ADDR_W=8 and MEM8_DEPTH=256.
  - The state typedef {IDLE, STREAM, DRAIN}.
  - FIFO_DEPTH=2.
- Sub-module inpmem_bank: LANES mem8 instances with a shared address and D/Q split per lane. It takes a bank-select plus per-lane enable and generates each lane's active-low CEN. It is instantiated NUM_BANKS times via generate.
- The streamer FSM, credit logic and 2-entry FIFO stay in the top module.

Test Plan:
- Setup: LANES=2, NUM_BANKS=4.
  - Write 0xA1B2 to addr 0x0105 with be=2'b11.
  - Burst base=0x0105, len=1.
  - Required: out_data=0xA1B2 with out_last=1 in the cycle after E2, then done pulses the next cycle.
- Write 0xFFFF to 0x0010, then 0x1200 with be=2'b10 to the same address. Read it back: required result 0x12FF.
- Fill addrs 0x03FE, 0x03FF, 0x0000, 0x0001 with 1, 2, 3, 4. Burst base=0x03FE, len=4: required stream 1, 2, 3, 4 (wrap-around), with out_last on the 4th beat only.
- Burst len=8 across a bank boundary (0x00FC..0x0103), with out_ready toggling pseudo-randomly. Required:
  - exactly 8 ordered beats;
  - data stable while stalled;
  - wr_ready=0 throughout busy.
- rd_len=0 → done pulses next cycle, out_valid never rises, busy stays 0.
- Assert rst_n=0 for one cycle mid-burst after beat 3 of 8. Required:
  - next cycle out_valid=0, busy=0, wr_ready=1, no done pulse;
  - a new burst then returns the correct, unaltered data.
